pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
Pipelined WIDTH-bit adder with valid/ready handshakes. It is the stage that feeds operands into the synthesis timing harness and consumes its results in a streaming context. The add is split into CHUNK-bit slices, one slice per pipeline stage, and the carry is registered between stages. This gives a short critical path at a latency of WIDTH/CHUNK cycles and a throughput of one result per cycle.

Parameters:
WIDTH, 32, operand and sum width in bits.
CHUNK, 8, bits added per pipeline stage. WIDTH % CHUNK must be 0; elaboration fails otherwise.
STAGES, WIDTH/CHUNK, derived localparam and never overridden; pipeline depth and latency.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream presents a, b, cin.
in_ready  output  1  block accepts this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry in.
out_valid  output  1  s and cout are valid.
out_ready  input  1  downstream accepts this cycle.
s  output  WIDTH  sum, a+b+cin mod 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Stage k (k = 0..STAGES-1) holds these registers:
  - vld[k]
  - the remaining upper operand bits a/b [WIDTH-1:(k+1)*CHUNK]
  - the partial sum [(k+1)*CHUNK-1:0]
  - carry[k], the carry out of bit (k+1)*CHUNK-1
- Stage 0 computes a[CHUNK-1:0] + b[CHUNK-1:0] + cin directly from the inputs.
- Stage k>0 computes its slice from the operand bits registered in stage k-1 plus carry[k-1], then appends the result above the partial sum.
- Advance rule: adv[STAGES-1] = !vld[STAGES-1] || out_ready. For k < STAGES-1, adv[k] = !vld[k] || adv[k+1]. This collapses bubbles and fills empty stages even when downstream stalls.
- in_ready = adv[0]. It is purely combinational from vld and out_ready; there is no path from in_valid to in_ready.
- Accept: in_valid && in_ready loads stage 0.
- When adv[k] is true, stage k loads from stage k-1 (or from the inputs) and vld[k] <= vld[k-1] (or in_valid). When adv[k] is false, stage k holds all its registers.
- Outputs:
  - out_valid = vld[STAGES-1].
  - s = the partial sum of the last stage (full WIDTH).
  - cout = carry[STAGES-1].
  - While out_valid && !out_ready, s and cout stay stable.
- Latency: an accept at edge N with the pipeline unstalled gives out_valid=1 after edge N+STAGES-1. Throughput is 1/cycle with out_ready held high.
- Capacity: up to STAGES transactions in flight. With out_ready=0 the pipeline fills completely and in_ready drops to 0.
- Simultaneous events: when the last stage is full and out_ready=1, a new accept in the same cycle is legal. The occupancy then stays unchanged.
- Reset: rst_n low clears every vld[k] and carry[k] immediately, asynchronously. out_valid=0, cout=0 and in_ready=1 while in reset. Data registers need not be reset, but s must read 0 during reset. Transactions in flight are discarded with no partial output. The first accept is allowed on the first rising edge after rst_n deasserts.
- Arithmetic: unsigned, modulo 2^WIDTH. cout is the true carry out of the full add, including the cin=1 wrap case.
- Degenerate case CHUNK == WIDTH: a single stage with latency 1, and the same handshake rules apply.

Decomposition:
- Package pipe_adder_pkg holds:
  - the function computing STAGES and checking divisibility;
  - a typedef for a chunk-sum result struct {logic carry; logic [CHUNK-1:0] sum} built with the parameterised width.
- One sub-module, pipe_adder_stage. It is a single slice register stage with the handshake: inputs are the upstream payload, valid and downstream adv; outputs are the registered payload, valid and its own adv. pipe_adder instantiates it STAGES times with a generate loop.

Test Plan:
1. WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0, cin=1, out_ready=1 -> 4 cycles later out_valid=1, s=0x00000000, cout=1.
2. a=0x12345678, b=0x87654321, cin=0 -> s=0x99999999, cout=0. Then a=0x80000000, b=0x80000000 -> s=0, cout=1.
3. Eight back-to-back accepts of random operands with out_ready=1 -> eight results on consecutive cycles, in order, each matching the reference a+b+cin.
4. Backpressure with out_ready=0 and in_valid held high -> exactly 4 accepts, then in_ready=0 with s/cout stable. Raise out_ready -> results drain in order with no loss or duplication.
5. Bubbles: in_valid toggling 1,0,1,0 with out_ready=1 -> out_valid pattern is the same sequence delayed 4 cycles.
6. Assert rst_n=0 with 3 transactions in flight -> out_valid=0 and cout=0 immediately. After release, one new accept gives one correct result and no stale data.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined slice adder.
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    // Returns 0 for an illegal width/chunk pair so the top can refuse to elaborate.
    function automatic int calc_stages(input int width, input int chunk);
        if (chunk <= 0 || width <= 0 || (width % chunk) != 0) begin
            return 0;
        end
        return width / chunk;
    endfunction

    typedef struct packed {
        logic                     carry;
        logic [DEFAULT_CHUNK-1:0] sum;
    } chunk_sum_t;

endpackage

// File: rtl/pipe_adder_stage.sv
// One slice of the adder: adds its CHUNK-bit slice and holds the payload under backpressure.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_sum,
    input  logic             up_carry,
    input  logic             down_adv,
    output logic             stage_vld,
    output logic [WIDTH-1:0] stage_a,
    output logic [WIDTH-1:0] stage_b,
    output logic [WIDTH-1:0] stage_sum,
    output logic             stage_carry,
    output logic             adv
);

    localparam int LO = IDX * CHUNK;
    localparam int SW = CHUNK + 1;

    typedef struct packed {
        logic             carry;
        logic [CHUNK-1:0] sum;
    } slice_t;

    slice_t           slice;
    logic [WIDTH-1:0] sum_next;

    always_comb begin
        slice = slice_t'({1'b0, up_a[LO +: CHUNK]} + {1'b0, up_b[LO +: CHUNK]} + SW'(up_carry));
    end

    // Lower slices come from earlier stages; bits above this slice are don't-care until filled.
    always_comb begin
        sum_next             = up_sum;
        sum_next[LO +: CHUNK] = slice.sum;
    end

    assign adv = !stage_vld || down_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld   <= 1'b0;
            stage_carry <= 1'b0;
            stage_sum   <= '0;
        end else if (adv) begin
            stage_vld   <= up_valid;
            stage_carry <= slice.carry;
            stage_sum   <= sum_next;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            stage_a <= up_a;
            stage_b <= up_b;
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder, one CHUNK-bit slice per stage, valid/ready on both sides.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (STAGES == 0) begin : g_bad_params
        $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] carry;
    logic [WIDTH-1:0]  a_pipe   [STAGES];
    logic [WIDTH-1:0]  b_pipe   [STAGES];
    logic [WIDTH-1:0]  sum_pipe [STAGES];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_a;
        logic [WIDTH-1:0] up_b;
        logic [WIDTH-1:0] up_sum;
        logic             up_carry;
        logic             down_adv;

        if (gi == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_a     = a;
            assign up_b     = b;
            assign up_sum   = '0;
            assign up_carry = cin;
        end else begin : g_chain
            assign up_valid = vld[gi-1];
            assign up_a     = a_pipe[gi-1];
            assign up_b     = b_pipe[gi-1];
            assign up_sum   = sum_pipe[gi-1];
            assign up_carry = carry[gi-1];
        end

        // An empty stage always advances, so bubbles collapse even while the output stalls.
        if (gi == STAGES - 1) begin : g_last
            assign down_adv = out_ready;
        end else begin : g_inner
            assign down_adv = adv[gi+1];
        end

        pipe_adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (gi)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .up_valid    (up_valid),
            .up_a        (up_a),
            .up_b        (up_b),
            .up_sum      (up_sum),
            .up_carry    (up_carry),
            .down_adv    (down_adv),
            .stage_vld   (vld[gi]),
            .stage_a     (a_pipe[gi]),
            .stage_b     (b_pipe[gi]),
            .stage_sum   (sum_pipe[gi]),
            .stage_carry (carry[gi]),
            .adv         (adv[gi])
        );
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];
    assign s         = sum_pipe[STAGES-1];
    assign cout      = carry[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: driver pushes expected results, a monitor pops and compares.
module tb_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int STAGES = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;

    pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
    );

    typedef struct {
        logic [WIDTH:0] exp;
        int             acc;
        bit             lat;
    } exp_t;

    exp_t           q[$];
    exp_t           mon_e;
    int             checks   = 0;
    int             failures = 0;
    int             cyc      = 0;
    int             accepts;
    bit             have_prev;
    logic [WIDTH:0] prev;

    logic [WIDTH-1:0] vec_a [8] = '{32'h0000_0001, 32'hFFFF_0000, 32'h00FF_00FF, 32'hDEAD_BEEF,
                                    32'h7FFF_FFFF, 32'h0000_00FF, 32'hAAAA_AAAA, 32'h1357_9BDF};
    logic [WIDTH-1:0] vec_b [8] = '{32'h0000_0001, 32'h0001_0000, 32'hFF00_FF01, 32'h2152_4111,
                                    32'h0000_0001, 32'h0000_0001, 32'h5555_5555, 32'hECA8_6420};
    logic             vec_c [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: samples at the falling edge, when outputs and out_ready are settled.
    initial begin
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev) begin
                    chk("hold_payload", 64'({cout, s}), 64'(prev));
                    chk("hold_valid", 64'(out_valid), 64'd1);
                end
                have_prev = 1'b0;
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 64'({cout, s}), 64'h0);
                        checks--;
                        checks++;
                        if ({cout, s} === '0) begin
                            failures++;
                            $display("FAIL unexpected_output: got %h expected none", {cout, s});
                        end
                    end else if (out_ready) begin
                        mon_e = q.pop_front();
                        chk("sum", 64'({cout, s}), 64'(mon_e.exp));
                        $display("result s=%h cout=%b exp=%h cyc=%0d", s, cout, mon_e.exp, cyc);
                        if (mon_e.lat) begin
                            chk("latency", 64'(cyc - mon_e.acc), 64'(STAGES - 1));
                        end
                    end else begin
                        have_prev = 1'b1;
                        prev      = {cout, s};
                    end
                end
            end
        end
    end

    // Entry and exit at 2 time units after a rising edge.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                        input logic [WIDTH:0] exp, input bit lat);
        int n;
        n        = 0;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end else begin
            q.push_back('{exp, cyc + 1, lat});
            $display("accept a=%h b=%h cin=%b cyc=%0d", ta, tb_v, tc, cyc + 1);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n;
        n        = 0;
        in_valid = 1'b0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_done", 64'(n < 100), 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_s", 64'(s), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;

        // Full carry ripple through every slice
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000, 1'b1);
        drain();
        send(32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000, 1'b1);
        drain();

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            send(vec_a[i], vec_b[i], vec_c[i], ref_add(vec_a[i], vec_b[i], vec_c[i]), 1'b1);
        end
        drain();

        // Backpressure: pipeline fills to exactly STAGES entries
        out_ready = 1'b0;
        accepts   = 0;
        for (int i = 0; i < 6; i++) begin
            a        = vec_a[i];
            b        = vec_b[7-i];
            cin      = vec_c[i];
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                q.push_back('{ref_add(vec_a[i], vec_b[7-i], vec_c[i]), cyc + 1, 1'b0});
                accepts++;
                $display("accept a=%h b=%h cin=%b cyc=%0d", a, b, cin, cyc + 1);
            end
            @(posedge clk);
            #2;
        end
        chk("bp_accepts", 64'(accepts), 64'(STAGES));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        drain();

        // Bubbles: 1,0,1,0 pattern must reappear STAGES-1 edges later
        send(32'h0000_000F, 32'h0000_0001, 1'b0, 33'h0_0000_0010, 1'b1);
        idle();
        send(32'h00FF_FFFF, 32'h0000_0001, 1'b1, 33'h0_0100_0001, 1'b1);
        idle();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF, 1'b1);
        idle();
        drain();

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 1'b0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_cout", 64'(cout), 64'd0);
        chk("midreset_s", 64'(s), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(32'h0000_1000, 32'h0000_0234, 1'b1, 33'h0_0000_1235, 1'b1);
        drain();
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        chk("final_idle", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
